// File: rtl/wbgpio_pkg.sv
// Shared register map and bus helpers for the Wishbone GPIO interrupt controller.
package wbgpio_pkg;

  localparam int WB_DW = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CFG  = 2'd3;

  // Lower half-word fields are only updated when both low byte lanes are selected.
  function automatic logic sel_lo(input logic [3:0] sel);
    return sel[0] & sel[1];
  endfunction

  function automatic logic sel_hi(input logic [3:0] sel);
    return sel[2] & sel[3];
  endfunction

endpackage

// File: rtl/wbgpio_irqctl_if.sv
// Wishbone pipelined slave bundle between a bus master and the GPIO controller.
interface wbgpio_irqctl_if;

  logic                        i_wb_cyc;
  logic                        i_wb_stb;
  logic                        i_wb_we;
  logic [1:0]                  i_wb_addr;
  logic [wbgpio_pkg::WB_DW-1:0] i_wb_data;
  logic [3:0]                  i_wb_sel;
  logic                        o_wb_stall;
  logic                        o_wb_ack;
  logic [wbgpio_pkg::WB_DW-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_data
  );

endinterface

// File: rtl/gpio_debounce.sv
// One pin: two-flop synchronizer followed by a tick-paced three-sample debouncer.
module gpio_debounce (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_tick,
  input  logic i_pin,
  output logic o_state,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] sync;
  logic [1:0] cnt;
  logic       differ;
  logic       flip;

  assign differ = sync[1] != o_state;
  assign flip   = i_tick && differ && (cnt == 2'd2);

  // Edge pulses line up with the new debounced value so pending logic sees them one cycle later.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync    <= 2'b00;
      cnt     <= 2'd0;
      o_state <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      sync   <= {sync[0], i_pin};
      o_rise <= flip && !o_state;
      o_fall <= flip && o_state;
      if (i_tick) begin
        if (flip) begin
          cnt     <= 2'd0;
          o_state <= ~o_state;
        end else if (differ) begin
          cnt <= cnt + 2'd1;
        end else begin
          cnt <= 2'd0;
        end
      end
    end
  end

endmodule

// File: rtl/wbgpio_irqctl.sv
// Wishbone GPIO input block: debounced pins, edge-pending bits with W1C, masked interrupt.
module wbgpio_irqctl
  import wbgpio_pkg::*;
#(
  parameter int          NIN         = 16,
  parameter logic [15:0] DEFAULT_LIM = 16'd999
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  wbgpio_irqctl_if.slave  wb,
  input  logic [NIN-1:0]  i_gpio,
  output logic            o_int
);

  logic           accept;
  logic           wr_en;
  logic           wr_pend;
  logic           wr_mask;
  logic           wr_lim;
  logic           wr_pol;
  logic           tick;
  logic [15:0]    lim;
  logic [15:0]    presc;
  logic [NIN-1:0] pol;
  logic [NIN-1:0] mask;
  logic [NIN-1:0] pend;
  logic [NIN-1:0] deb;
  logic [NIN-1:0] rise;
  logic [NIN-1:0] fall;
  logic [NIN-1:0] set_bits;
  logic [NIN-1:0] clr_bits;
  logic           ack_q;
  logic [31:0]    rdata;
  logic [31:0]    rdata_q;

  assign accept  = wb.i_wb_cyc & wb.i_wb_stb;
  assign wr_en   = accept & wb.i_wb_we;
  assign wr_pend = wr_en && (wb.i_wb_addr == ADDR_PEND) && sel_lo(wb.i_wb_sel);
  assign wr_mask = wr_en && (wb.i_wb_addr == ADDR_MASK) && sel_lo(wb.i_wb_sel);
  assign wr_lim  = wr_en && (wb.i_wb_addr == ADDR_CFG)  && sel_lo(wb.i_wb_sel);
  assign wr_pol  = wr_en && (wb.i_wb_addr == ADDR_CFG)  && sel_hi(wb.i_wb_sel);

  assign tick     = (presc == lim);
  assign set_bits = (rise & pol) | (fall & ~pol);
  assign clr_bits = wr_pend ? wb.i_wb_data[NIN-1:0] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : gen_pin
      gpio_debounce u_deb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_tick    (tick),
        .i_pin     (i_gpio[gi]),
        .o_state   (deb[gi]),
        .o_rise    (rise[gi]),
        .o_fall    (fall[gi])
      );
    end
  endgenerate

  // A LIM write restarts the count so the new period starts cleanly from zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc <= '0;
    end else if (wr_lim || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Set wins over a same-cycle W1C because it is OR-ed in after the clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lim   <= DEFAULT_LIM;
      pol   <= '1;
      mask  <= '0;
      pend  <= '0;
      o_int <= 1'b0;
    end else begin
      if (wr_lim) lim <= wb.i_wb_data[15:0];
      if (wr_pol) pol <= wb.i_wb_data[16 +: NIN];
      if (wr_mask) mask <= wb.i_wb_data[NIN-1:0];
      pend  <= (pend & ~clr_bits) | set_bits;
      o_int <= |(pend & mask);
    end
  end

  always_comb begin
    rdata = '0;
    case (wb.i_wb_addr)
      ADDR_DATA: rdata[NIN-1:0] = deb;
      ADDR_PEND: rdata[NIN-1:0] = pend;
      ADDR_MASK: rdata[NIN-1:0] = mask;
      ADDR_CFG: begin
        rdata[15:0]     = lim;
        rdata[16 +: NIN] = pol;
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= accept;
      if (accept) rdata_q <= rdata;
    end
  end

  // A master abandoning the cycle must never see a stray ack.
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_ack   = ack_q & wb.i_wb_cyc;
  assign wb.o_wb_data  = rdata_q;

endmodule

// File: tb/tb_wbgpio_irqctl.sv
// Directed scenarios plus randomized bus/pin traffic against a behavioural register-map model.
module tb_wbgpio_irqctl;

  localparam int          NIN     = 16;
  localparam logic [15:0] DEF_LIM = 16'd999;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic [NIN-1:0] gpio  = '0;
  logic           irq;

  wbgpio_irqctl_if bus ();

  wbgpio_irqctl #(.NIN(NIN), .DEFAULT_LIM(DEF_LIM)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (bus),
    .i_gpio    (gpio),
    .o_int     (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus per-pin debounce history.
  int          m_age;
  int          m_lim;
  logic [15:0] m_pol, m_mask, m_pend, m_deb;
  logic [15:0] m_rise, m_fall;
  logic [15:0] m_h1, m_h2;
  int          m_run [NIN];
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        m_int;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_age   = 0;
    m_lim   = DEF_LIM;
    m_pol   = 16'hFFFF;
    m_mask  = '0;
    m_pend  = '0;
    m_deb   = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_h1    = '0;
    m_h2    = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
    m_int   = 1'b0;
    for (int i = 0; i < NIN; i++) m_run[i] = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] addr);
    case (addr)
      2'd0:    return {16'h0, m_deb};
      2'd1:    return {16'h0, m_pend};
      2'd2:    return {16'h0, m_mask};
      default: return {m_pol, 16'(m_lim)};
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs that were applied before it.
  task automatic model_step();
    logic        accept, wr, tick;
    logic [15:0] set_bits, clr_bits, n_rise, n_fall;
    if (!rst_n) begin
      model_reset();
      return;
    end
    accept   = bus.i_wb_cyc && bus.i_wb_stb;
    wr       = accept && bus.i_wb_we;
    tick     = (m_age % (m_lim + 1)) == m_lim;
    set_bits = (m_rise & m_pol) | (m_fall & ~m_pol);
    clr_bits = (wr && bus.i_wb_addr == 2'd1 && bus.i_wb_sel[1:0] == 2'b11) ? bus.i_wb_data[15:0] : 16'h0;
    m_int = |(m_pend & m_mask);
    m_ack = accept;
    if (accept) m_rdata = model_read(bus.i_wb_addr);
    n_rise = '0;
    n_fall = '0;
    for (int i = 0; i < NIN; i++) begin
      if (tick) begin
        if (m_h2[i] != m_deb[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == 3) begin
          m_run[i]  = 0;
          n_rise[i] = !m_deb[i];
          n_fall[i] = m_deb[i];
          m_deb[i]  = !m_deb[i];
        end
      end
    end
    m_rise = n_rise;
    m_fall = n_fall;
    m_h2   = m_h1;
    m_h1   = gpio;
    m_pend = (m_pend & ~clr_bits) | set_bits;
    m_age++;
    if (wr && bus.i_wb_addr == 2'd2 && bus.i_wb_sel[1:0] == 2'b11) m_mask = bus.i_wb_data[15:0];
    if (wr && bus.i_wb_addr == 2'd3 && bus.i_wb_sel[1:0] == 2'b11) begin
      m_lim = int'(bus.i_wb_data[15:0]);
      m_age = 0;
    end
    if (wr && bus.i_wb_addr == 2'd3 && bus.i_wb_sel[3:2] == 2'b11) m_pol = bus.i_wb_data[31:16];
  endtask

  task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                               input logic [1:0] addr, input logic [31:0] data, input logic [3:0] sel);
    bus.i_wb_cyc  = cyc;
    bus.i_wb_stb  = stb;
    bus.i_wb_we   = we;
    bus.i_wb_addr = addr;
    bus.i_wb_data = data;
    bus.i_wb_sel  = sel;
    @(posedge clk);
    model_step();
    #1;
    checkOutput("ack", {31'h0, bus.o_wb_ack}, {31'h0, m_ack && bus.i_wb_cyc});
    checkOutput("rdata", bus.o_wb_data, m_rdata);
    checkOutput("irq", {31'h0, irq}, {31'h0, m_int});
    checkOutput("stall", {31'h0, bus.o_wb_stall}, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] sel);
    applyStimulus(1'b1, 1'b1, 1'b1, addr, data, sel);
    applyStimulus(1'b1, 1'b0, 1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0, 4'hF);
    data = bus.o_wb_data;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  logic [31:0] rd;
  logic [3:0]  rsel;

  initial begin
    bus.i_wb_cyc  = 1'b0;
    bus.i_wb_stb  = 1'b0;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = 2'd0;
    bus.i_wb_data = 32'h0;
    bus.i_wb_sel  = 4'h0;
    model_reset();
    idle(2);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Reset values visible through the bus
    bus_read(2'd3, rd);
    checkOutput("reset_cfg", rd, 32'hFFFF03E7);
    bus_read(2'd0, rd);
    checkOutput("reset_data", rd, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);

    // Rising edge on pin 0 with tick every cycle
    bus_write(2'd3, 32'hFFFF_0000, 4'hF);
    bus_write(2'd2, 32'h0000_0001, 4'hF);
    gpio[0] = 1'b1;
    idle(6);
    bus_read(2'd0, rd);
    checkOutput("pin0_data", rd & 32'h1, 32'h1);
    bus_read(2'd1, rd);
    checkOutput("pin0_pend", rd, 32'h1);
    checkOutput("pin0_irq", {31'h0, irq}, 32'h1);

    // Two-cycle glitch on pin 1 is filtered out
    gpio[1] = 1'b1;
    idle(2);
    gpio[1] = 1'b0;
    idle(8);
    bus_read(2'd0, rd);
    checkOutput("glitch_data", rd, 32'h1);
    bus_read(2'd1, rd);
    checkOutput("glitch_pend", rd, 32'h1);

    // Falling-edge polarity on pin 2
    bus_write(2'd3, 32'hFFFB_0000, 4'hF);
    gpio[2] = 1'b1;
    idle(8);
    bus_read(2'd1, rd);
    checkOutput("pol_rise_pend", rd & 32'h4, 32'h0);
    bus_read(2'd0, rd);
    checkOutput("pol_rise_data", rd & 32'h4, 32'h4);
    gpio[2] = 1'b0;
    idle(8);
    bus_read(2'd1, rd);
    checkOutput("pol_fall_pend", rd & 32'h4, 32'h4);

    // W1C colliding with a new set keeps the bit; a lone W1C clears it
    bus_write(2'd1, 32'h0000_FFFF, 4'h3);
    bus_read(2'd1, rd);
    checkOutput("w1c_all", rd, 32'h0);
    gpio[0] = 1'b0;
    idle(10);
    gpio[0] = 1'b1;
    for (int i = 0; i < 20 && !m_rise[0]; i++) idle(1);
    if (!m_rise[0]) checkOutput("collide_timeout", 32'h0, 32'h1);
    bus_write(2'd1, 32'h0000_0001, 4'h3);
    bus_read(2'd1, rd);
    checkOutput("collide_pend", rd, 32'h1);
    bus_write(2'd1, 32'h0000_0001, 4'h3);
    bus_read(2'd1, rd);
    checkOutput("w1c_pend", rd, 32'h0);
    checkOutput("w1c_irq", {31'h0, irq}, 32'h0);

    // Randomized pins and bus traffic
    bus_write(2'd3, {16'($urandom), 16'($urandom_range(0, 3))}, 4'hF);
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NIN; i++)
        if ($urandom_range(0, 15) == 0) gpio[i] = !gpio[i];
      rsel = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      case ($urandom_range(0, 3))
        0: applyStimulus(1'($urandom), 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
        1: applyStimulus(1'b1, 1'b1, 1'b0, 2'($urandom), 32'h0, 4'hF);
        2: applyStimulus(1'b1, 1'b1, 1'b1, 2'($urandom_range(1, 2)), $urandom, rsel);
        default: applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, {16'($urandom), 16'($urandom_range(0, 3))}, rsel);
      endcase
    end

    // Reset pulse while a read is outstanding
    gpio = '0;
    idle(20);
    bus_write(2'd2, 32'h0000_FFFF, 4'hF);
    bus_write(2'd3, 32'h1234_0005, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 32'h0, 4'hF);
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_ack", {31'h0, bus.o_wb_ack}, 32'h0);
    checkOutput("rst_rdata", bus.o_wb_data, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    rst_n = 1'b1;
    idle(1);
    bus_read(2'd3, rd);
    checkOutput("rst_cfg", rd, 32'hFFFF03E7);
    bus_read(2'd2, rd);
    checkOutput("rst_mask", rd, 32'h0);
    bus_read(2'd1, rd);
    checkOutput("rst_pend", rd, 32'h0);
    bus_read(2'd0, rd);
    checkOutput("rst_data", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
